// File: rtl/video_pkg.sv
// video_pkg: mode table, mode/state enums and timing helpers
// shared by the switchable raster timing path.
package video_pkg;

  localparam int MT_W     = 12;
  localparam int MODE_MAX = 4;

  typedef enum logic [1:0] {
    VM_480P  = 2'd0,
    VM_720P  = 2'd1,
    VM_1080P = 2'd2,
    VM_NONE  = 2'd3
  } VideoMode;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } SwitchState;

  typedef struct packed {
    logic [MT_W-1:0] h_vis;
    logic [MT_W-1:0] h_fp;
    logic [MT_W-1:0] h_sync;
    logic [MT_W-1:0] h_bp;
    logic [MT_W-1:0] v_vis;
    logic [MT_W-1:0] v_fp;
    logic [MT_W-1:0] v_sync;
    logic [MT_W-1:0] v_bp;
    logic            hpol;
    logic            vpol;
  } ModeTiming;

  typedef ModeTiming [MODE_MAX-1:0] ModeTable;

  localparam ModeTiming MT_480P = '{
    h_vis: 12'd720, h_fp: 12'd16, h_sync: 12'd62, h_bp: 12'd60,
    v_vis: 12'd480, v_fp: 12'd9, v_sync: 12'd6, v_bp: 12'd30,
    hpol: 1'b0, vpol: 1'b0
  };

  localparam ModeTiming MT_720P = '{
    h_vis: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
    v_vis: 12'd720, v_fp: 12'd5, v_sync: 12'd5, v_bp: 12'd20,
    hpol: 1'b1, vpol: 1'b1
  };

  localparam ModeTiming MT_1080P = '{
    h_vis: 12'd1920, h_fp: 12'd88, h_sync: 12'd44, h_bp: 12'd148,
    v_vis: 12'd1080, v_fp: 12'd4, v_sync: 12'd5, v_bp: 12'd36,
    hpol: 1'b1, vpol: 1'b1
  };

  localparam ModeTiming MT_UNUSED = '0;

  // Index 0 sits in the least significant slot.
  localparam ModeTable MODE_TABLE = {
    MT_UNUSED, MT_1080P, MT_720P, MT_480P
  };

  function automatic logic [MT_W-1:0] h_total(input ModeTiming t);
    return t.h_vis + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic logic [MT_W-1:0] v_total(input ModeTiming t);
    return t.v_vis + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter: X/Y raster counters plus registered sync,
// data-enable and frame-start outputs for one loaded mode.
module raster_counter
  import video_pkg::*;
#(
  parameter int        CW   = 12,
  parameter ModeTiming INIT = MODE_TABLE[VM_720P]
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  ModeTiming     cfg,
  input  logic          en,
  output logic [CW-1:0] counterX,
  output logic [CW-1:0] counterY,
  output logic [CW-1:0] visible_counterX,
  output logic [CW-1:0] visible_counterY,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          starttrigger,
  output logic          frame_end
);

  typedef struct packed {
    logic [CW-1:0] h_vis;
    logic [CW-1:0] hs_on;
    logic [CW-1:0] hs_off;
    logic [CW-1:0] h_last;
    logic [CW-1:0] v_vis;
    logic [CW-1:0] vs_on;
    logic [CW-1:0] vs_off;
    logic [CW-1:0] v_last;
    logic          hpol;
    logic          vpol;
  } limits_t;

  // Derived limits are registered at load so the per-pixel
  // compare path never sees the adders.
  function automatic limits_t to_limits(input ModeTiming t);
    limits_t l;
    l.h_vis  = CW'(t.h_vis);
    l.hs_on  = CW'(t.h_vis + t.h_fp);
    l.hs_off = CW'(t.h_vis + t.h_fp + t.h_sync);
    l.h_last = CW'(h_total(t) - MT_W'(1));
    l.v_vis  = CW'(t.v_vis);
    l.vs_on  = CW'(t.v_vis + t.v_fp);
    l.vs_off = CW'(t.v_vis + t.v_fp + t.v_sync);
    l.v_last = CW'(v_total(t) - MT_W'(1));
    l.hpol   = t.hpol;
    l.vpol   = t.vpol;
    return l;
  endfunction

  limits_t lim_q;
  logic    last_x;
  logic    last_y;
  logic    act;
  logic    hs_act;
  logic    vs_act;
  logic    origin;

  assign last_x = counterX >= lim_q.h_last;
  assign last_y = counterY >= lim_q.v_last;
  assign frame_end = last_x && last_y;

  assign act = (counterX < lim_q.h_vis) &&
               (counterY < lim_q.v_vis);
  assign hs_act = (counterX >= lim_q.hs_on) &&
                  (counterX < lim_q.hs_off);
  assign vs_act = (counterY >= lim_q.vs_on) &&
                  (counterY < lim_q.vs_off);
  assign origin = (counterX == '0) && (counterY == '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lim_q            <= to_limits(INIT);
      counterX         <= '0;
      counterY         <= '0;
      visible_counterX <= '0;
      visible_counterY <= '0;
      hsync            <= ~INIT.hpol;
      vsync            <= ~INIT.vpol;
      de               <= 1'b0;
      starttrigger     <= 1'b0;
    end else begin
      hsync            <= lim_q.hpol ? hs_act : !hs_act;
      vsync            <= lim_q.vpol ? vs_act : !vs_act;
      de               <= act && en;
      visible_counterX <= (act && en) ? counterX : '0;
      visible_counterY <= (act && en) ? counterY : '0;
      starttrigger     <= origin && en;
      if (load) begin
        lim_q    <= to_limits(cfg);
        counterX <= '0;
        counterY <= '0;
      end else if (last_x) begin
        counterX <= '0;
        counterY <= last_y ? '0 : counterY + CW'(1);
      end else begin
        counterX <= counterX + CW'(1);
      end
    end
  end

endmodule

// File: rtl/video_timing_switch.sv
// video_timing_switch: raster timing with handshake-driven mode
// changes applied at frame end, followed by blanked settle frames.
module video_timing_switch
  import video_pkg::*;
#(
  parameter int       CW            = 12,
  parameter int       NUM_MODES     = 3,
  parameter int       MODE_W        = 2,
  parameter int       DEFAULT_MODE  = 1,
  parameter int       SETTLE_FRAMES = 2,
  parameter ModeTable TIMING        = MODE_TABLE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              mode_req_valid,
  output logic              mode_req_ready,
  output logic              mode_err,
  output logic [MODE_W-1:0] mode_active,
  output logic              switching,
  output logic [CW-1:0]     counterX,
  output logic [CW-1:0]     counterY,
  output logic [CW-1:0]     visible_counterX,
  output logic [CW-1:0]     visible_counterY,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              starttrigger
);

  localparam logic [MODE_W-1:0] DEF = MODE_W'(DEFAULT_MODE);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_FRAMES);
  localparam SwitchState AFTER_LOAD =
    (SETTLE_FRAMES == 0) ? RUN : SETTLE;

  SwitchState        state_q;
  SwitchState        state_d;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic [MODE_W-1:0] pend_q;
  logic [MODE_W-1:0] pend_d;
  logic [3:0]        settle_q;
  logic [3:0]        settle_d;
  logic              err_d;
  logic              load;
  logic              en;
  logic              frame_end;
  logic              bad_req;

  assign bad_req        = int'(mode_req) >= NUM_MODES;
  assign mode_req_ready = state_q == RUN;
  assign switching      = state_q != RUN;
  assign mode_active    = mode_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    settle_d = settle_q;
    err_d    = 1'b0;
    load     = 1'b0;
    en       = 1'b1;
    unique case (state_q)
      RUN: begin
        if (mode_req_valid) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else if (mode_req != mode_q) begin
            pend_d  = mode_req;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (frame_end) begin
          en       = 1'b0;
          load     = 1'b1;
          mode_d   = pend_q;
          settle_d = SETTLE_INIT;
          state_d  = AFTER_LOAD;
        end
      end
      SETTLE: begin
        en = 1'b0;
        if (frame_end) begin
          if (settle_q <= 4'd1) begin
            state_d = RUN;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= RUN;
      mode_q   <= DEF;
      pend_q   <= DEF;
      settle_q <= '0;
      mode_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      settle_q <= settle_d;
      mode_err <= err_d;
    end
  end

  raster_counter #(
    .CW   (CW),
    .INIT (TIMING[DEF])
  ) u_raster (
    .clock            (clock),
    .reset_n          (reset_n),
    .load             (load),
    .cfg              (TIMING[pend_q]),
    .en               (en),
    .counterX         (counterX),
    .counterY         (counterY),
    .visible_counterX (visible_counterX),
    .visible_counterY (visible_counterY),
    .hsync            (hsync),
    .vsync            (vsync),
    .de               (de),
    .starttrigger     (starttrigger),
    .frame_end        (frame_end)
  );

endmodule

// File: tb/tb_video_timing_switch.sv
// tb_video_timing_switch: directed checks on shrunk mode tables
// plus a short run of the real 720p table.
module tb_video_timing_switch;
  import video_pkg::*;

  localparam ModeTiming S0 = '{
    h_vis: 12'd8, h_fp: 12'd2, h_sync: 12'd2, h_bp: 12'd2,
    v_vis: 12'd4, v_fp: 12'd1, v_sync: 12'd1, v_bp: 12'd1,
    hpol: 1'b0, vpol: 1'b0
  };
  localparam ModeTiming S1 = '{
    h_vis: 12'd10, h_fp: 12'd2, h_sync: 12'd2, h_bp: 12'd2,
    v_vis: 12'd6, v_fp: 12'd1, v_sync: 12'd1, v_bp: 12'd2,
    hpol: 1'b1, vpol: 1'b1
  };
  localparam ModeTiming S2 = '{
    h_vis: 12'd12, h_fp: 12'd2, h_sync: 12'd3, h_bp: 12'd3,
    v_vis: 12'd8, v_fp: 12'd1, v_sync: 12'd2, v_bp: 12'd1,
    hpol: 1'b1, vpol: 1'b1
  };
  localparam ModeTiming S3 = '0;
  localparam ModeTable SMALL = {S3, S2, S1, S0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_val, a_rdy, a_err, a_sw;
  logic        a_hs, a_vs, a_de, a_st;
  logic [1:0]  a_req, a_mode;
  logic [11:0] a_x, a_y, a_vx, a_vy;

  logic        b_rst, b_val, b_rdy, b_err, b_sw;
  logic        b_hs, b_vs, b_de, b_st;
  logic [1:0]  b_req, b_mode;
  logic [11:0] b_x, b_y, b_vx, b_vy;

  logic        r_rst, r_val, r_rdy, r_err, r_sw;
  logic        r_hs, r_vs, r_de, r_st;
  logic [1:0]  r_req, r_mode;
  logic [11:0] r_x, r_y, r_vx, r_vy;

  video_timing_switch #(
    .SETTLE_FRAMES (2),
    .TIMING        (SMALL)
  ) dut_a (
    .clock (clk), .reset_n (a_rst),
    .mode_req (a_req), .mode_req_valid (a_val),
    .mode_req_ready (a_rdy), .mode_err (a_err),
    .mode_active (a_mode), .switching (a_sw),
    .counterX (a_x), .counterY (a_y),
    .visible_counterX (a_vx), .visible_counterY (a_vy),
    .hsync (a_hs), .vsync (a_vs), .de (a_de),
    .starttrigger (a_st)
  );

  video_timing_switch #(
    .DEFAULT_MODE  (2),
    .SETTLE_FRAMES (0),
    .TIMING        (SMALL)
  ) dut_b (
    .clock (clk), .reset_n (b_rst),
    .mode_req (b_req), .mode_req_valid (b_val),
    .mode_req_ready (b_rdy), .mode_err (b_err),
    .mode_active (b_mode), .switching (b_sw),
    .counterX (b_x), .counterY (b_y),
    .visible_counterX (b_vx), .visible_counterY (b_vy),
    .hsync (b_hs), .vsync (b_vs), .de (b_de),
    .starttrigger (b_st)
  );

  video_timing_switch dut_r (
    .clock (clk), .reset_n (r_rst),
    .mode_req (r_req), .mode_req_valid (r_val),
    .mode_req_ready (r_rdy), .mode_err (r_err),
    .mode_active (r_mode), .switching (r_sw),
    .counterX (r_x), .counterY (r_y),
    .visible_counterX (r_vx), .visible_counterY (r_vy),
    .hsync (r_hs), .vsync (r_vs), .de (r_de),
    .starttrigger (r_st)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int a_den, a_stn, a_hshi, a_hslo, a_vshi, a_maxx, a_maxy, a_vxmax;
  int b_den, b_stn, b_hslo, b_vslo, b_maxx;
  int r_den, r_stn, r_hshi, r_nrise;
  int r_rise[2];
  int vbad = 0;
  logic r_hsp = 1'b0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    a_den = 0; a_stn = 0; a_hshi = 0; a_hslo = 0; a_vshi = 0;
    a_maxx = 0; a_maxy = 0; a_vxmax = 0;
    b_den = 0; b_stn = 0; b_hslo = 0; b_vslo = 0; b_maxx = 0;
    r_den = 0; r_stn = 0; r_hshi = 0; r_nrise = 0;
    r_rise[0] = 0; r_rise[1] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (a_de) a_den++;
    if (a_st) a_stn++;
    if (a_hs) a_hshi++; else a_hslo++;
    if (a_vs) a_vshi++;
    if (int'(a_x) > a_maxx) a_maxx = int'(a_x);
    if (int'(a_y) > a_maxy) a_maxy = int'(a_y);
    if (int'(a_vx) > a_vxmax) a_vxmax = int'(a_vx);
    if (b_de) b_den++;
    if (b_st) b_stn++;
    if (!b_hs) b_hslo++;
    if (!b_vs) b_vslo++;
    if (int'(b_x) > b_maxx) b_maxx = int'(b_x);
    if (r_de) r_den++;
    if (r_st) r_stn++;
    if (r_hs) r_hshi++;
    if (r_hs && !r_hsp) begin
      if (r_nrise < 2) r_rise[r_nrise] = cyc;
      r_nrise++;
    end
    r_hsp = r_hs;
    if (!a_de && (a_vx != '0 || a_vy != '0)) vbad++;
    if (!b_de && (b_vx != '0 || b_vy != '0)) vbad++;
    if (!r_de && (r_vx != '0 || r_vy != '0)) vbad++;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    a_rst = 0; a_val = 0; a_req = '0;
    b_rst = 0; b_val = 0; b_req = '0;
    r_rst = 0; r_val = 0; r_req = '0;
    clr();
    ticks(3);
    check("rst_x", a_x, 0);
    check("rst_y", a_y, 0);
    check("rst_de", a_de, 0);
    check("rst_st", a_st, 0);
    check("rst_err", a_err, 0);
    check("rst_sw", a_sw, 0);
    check("rst_rdy", a_rdy, 1);
    check("rst_mode", a_mode, 1);
    check("rst_hs", a_hs, 0);
    check("rst_vs", a_vs, 0);
    check("rst_b_hs", b_hs, 0);
    check("rst_r_rdy", r_rdy, 1);

    // real 720p table: two lines
    r_rst = 1;
    clr();
    ticks(3300);
    check("r_de", r_den, 2560);
    check("r_hs_hi", r_hshi, 80);
    check("r_st", r_stn, 1);
    check("r_rises", r_nrise, 2);
    check("r_hs_per", r_rise[1] - r_rise[0], 1650);
    check("r_x", r_x, 0);
    check("r_y", r_y, 2);
    check("r_vs", r_vs, 0);
    check("r_idle", {r_err, r_sw, r_mode}, 3'b001);

    // two frames of shrunk 720p
    a_rst = 1;
    clr();
    ticks(320);
    check("f_de", a_den, 120);
    check("f_st", a_stn, 2);
    check("f_hs", a_hshi, 40);
    check("f_vs", a_vshi, 32);
    check("f_vxmax", a_vxmax, 9);
    check("f_x", a_x, 0);
    check("f_y", a_y, 0);

    // invalid index
    a_req = 2'd3; a_val = 1;
    tick();
    a_val = 0;
    check("err_hi", a_err, 1);
    check("err_rdy", a_rdy, 1);
    check("err_mode", a_mode, 1);
    tick();
    check("err_lo", a_err, 0);
    check("err_x", a_x, 2);

    // same-mode request
    a_req = 2'd1; a_val = 1;
    tick();
    a_val = 0;
    check("same_sw", a_sw, 0);
    check("same_rdy", a_rdy, 1);
    check("same_x", a_x, 3);

    // switch to mode 0 mid-frame
    ticks(77);
    a_req = 2'd0; a_val = 1;
    tick();
    a_val = 0;
    check("pend_rdy", a_rdy, 0);
    check("pend_sw", a_sw, 1);
    ticks(78);
    check("pend_x", a_x, 15);
    check("pend_y", a_y, 9);
    check("pend_mode", a_mode, 1);
    tick();
    check("load_x", a_x, 0);
    check("load_y", a_y, 0);
    check("load_mode", a_mode, 0);
    check("load_sw", a_sw, 1);
    clr();
    ticks(196);
    check("set_de", a_den, 0);
    check("set_st", a_stn, 0);
    check("set_hs_lo", a_hslo, 28);
    check("set_maxx", a_maxx, 13);
    check("set_maxy", a_maxy, 6);
    check("set_done", a_sw, 0);
    check("set_rdy", a_rdy, 1);
    clr();
    tick();
    check("f3_st", a_st, 1);
    ticks(97);
    check("f3_de", a_den, 32);
    check("f3_stn", a_stn, 1);

    // reset during SETTLE of 720p -> 1080p
    a_rst = 0;
    ticks(2);
    check("r5_mode0", a_mode, 1);
    a_req = 2'd2; a_val = 1; a_rst = 1;
    tick();
    a_val = 0;
    ticks(159);
    ticks(50);
    check("r5_sw", a_sw, 1);
    check("r5_mode2", a_mode, 2);
    a_rst = 0;
    ticks(2);
    check("r5_mode", a_mode, 1);
    check("r5_swlo", a_sw, 0);
    check("r5_rdy", a_rdy, 1);
    check("r5_x", a_x, 0);
    a_rst = 1;
    clr();
    tick();
    check("r5_st", a_st, 1);
    ticks(159);
    check("r5_de", a_den, 60);
    check("r5_stn", a_stn, 1);

    // zero settle frames, 1080p -> 480p
    b_rst = 1;
    b_req = 2'd0; b_val = 1;
    tick();
    b_val = 0;
    check("z_rdy", b_rdy, 0);
    ticks(239);
    check("z_sw", b_sw, 0);
    check("z_mode", b_mode, 0);
    check("z_x", b_x, 0);
    clr();
    tick();
    check("z_st", b_st, 1);
    ticks(97);
    check("z_de", b_den, 32);
    check("z_stn", b_stn, 1);
    check("z_maxx", b_maxx, 13);
    check("z_hs_lo", b_hslo, 14);
    check("z_vs_lo", b_vslo, 14);
    check("z_err", b_err, 0);
    check("z_y", b_y, 0);
    check("vis_zero", vbad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
